// File: rtl/cpu_cache_controller_if.sv
// Bus bundle between the cache controller, the CPU, the tag/data arrays and main memory.
// The master modport is the controller's view; slave is the surrounding system's.
interface cpu_cache_controller_if #(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 16
);
  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  logic                    cpuRead;
  logic                    cpuWrite;
  logic [ADDR_WIDTH-1:0]   cpuAddress;
  logic [DATA_WIDTH-1:0]   cpuWriteData;
  logic [DATA_WIDTH-1:0]   cpuReadData;
  logic                    cpuWaitRequest;

  logic [INDEX_WIDTH-1:0]  cacheIndex;
  logic [OFFSET_WIDTH-1:0] cacheOffset;
  logic [TAG_WIDTH-1:0]    cacheTagIn;
  logic [DATA_WIDTH-1:0]   cacheDataIn;
  logic [1:0]              cacheStateIn;
  logic                    cacheWriteTag;
  logic                    cacheWriteData;
  logic                    cacheWriteState;
  logic                    cacheHit;
  logic [TAG_WIDTH-1:0]    cacheTagOut;
  logic [DATA_WIDTH-1:0]   cacheDataOut;
  logic [1:0]              cacheStateOut;
  logic                    accessEnable;

  logic                    memRead;
  logic                    memWrite;
  logic [ADDR_WIDTH-1:0]   memAddress;
  logic [DATA_WIDTH-1:0]   memDataOut;
  logic [DATA_WIDTH-1:0]   memDataIn;
  logic                    memWaitRequest;

  modport master (
    input  cpuRead, cpuWrite, cpuAddress, cpuWriteData,
    output cpuReadData, cpuWaitRequest,
    output cacheIndex, cacheOffset, cacheTagIn, cacheDataIn, cacheStateIn,
    output cacheWriteTag, cacheWriteData, cacheWriteState, accessEnable,
    input  cacheHit, cacheTagOut, cacheDataOut, cacheStateOut,
    output memRead, memWrite, memAddress, memDataOut,
    input  memDataIn, memWaitRequest
  );

  modport slave (
    output cpuRead, cpuWrite, cpuAddress, cpuWriteData,
    input  cpuReadData, cpuWaitRequest,
    input  cacheIndex, cacheOffset, cacheTagIn, cacheDataIn, cacheStateIn,
    input  cacheWriteTag, cacheWriteData, cacheWriteState, accessEnable,
    output cacheHit, cacheTagOut, cacheDataOut, cacheStateOut,
    input  memRead, memWrite, memAddress, memDataOut,
    output memDataIn, memWaitRequest
  );
endinterface

// File: rtl/cpu_cache_controller.sv
// Write-back cache controller: zero-wait hits, line write-back of dirty victims,
// word-by-word line fill from memory, then tag/state update and replay as a hit.
module cpu_cache_controller #(
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  cpu_cache_controller_if.master bus
);
  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  localparam logic [1:0] ST_INVALID = 2'b00;
  localparam logic [1:0] ST_CLEAN   = 2'b01;
  localparam logic [1:0] ST_DIRTY   = 2'b10;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;
  localparam logic [1:0] S_UPDATE    = 2'd3;

  localparam logic [OFFSET_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]              state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]    victim_tag_q, victim_tag_d;
  logic [TAG_WIDTH-1:0]    req_tag_q, req_tag_d;

  logic [TAG_WIDTH-1:0]    addr_tag;
  logic [INDEX_WIDTH-1:0]  addr_index;
  logic [OFFSET_WIDTH-1:0] addr_offset;
  logic                    req;
  logic                    mem_accept;

  assign addr_tag    = bus.cpuAddress[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign addr_index  = bus.cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign addr_offset = bus.cpuAddress[OFFSET_WIDTH-1:0];
  assign req         = bus.cpuRead | bus.cpuWrite;
  assign mem_accept  = ~bus.memWaitRequest;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    victim_tag_d = victim_tag_q;
    req_tag_d    = req_tag_q;

    bus.cacheIndex      = addr_index;
    bus.cacheOffset     = cnt_q;
    bus.cacheTagIn      = req_tag_q;
    bus.cacheDataIn     = bus.cpuWriteData;
    bus.cacheStateIn    = ST_INVALID;
    bus.cacheWriteTag   = 1'b0;
    bus.cacheWriteData  = 1'b0;
    bus.cacheWriteState = 1'b0;
    bus.accessEnable    = 1'b0;
    bus.memRead         = 1'b0;
    bus.memWrite        = 1'b0;
    bus.memAddress      = {req_tag_q, addr_index, cnt_q};
    bus.memDataOut      = bus.cacheDataOut;
    bus.cpuReadData     = '0;
    bus.cpuWaitRequest  = req;

    // Strobes are gated by reset so they drop combinationally, not at the next edge.
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          bus.cacheOffset = addr_offset;
          if (req) begin
            if (bus.cacheHit) begin
              bus.cpuWaitRequest = 1'b0;
              bus.accessEnable   = 1'b1;
              if (bus.cpuWrite) begin
                bus.cacheWriteData  = 1'b1;
                bus.cacheWriteState = 1'b1;
                bus.cacheDataIn     = bus.cpuWriteData;
                bus.cacheStateIn    = ST_DIRTY;
              end else begin
                bus.cpuReadData = bus.cacheDataOut;
              end
            end else begin
              victim_tag_d = bus.cacheTagOut;
              req_tag_d    = addr_tag;
              cnt_d        = '0;
              state_d      = (bus.cacheStateOut == ST_DIRTY) ? S_WRITEBACK : S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          bus.memWrite   = 1'b1;
          bus.memAddress = {victim_tag_q, addr_index, cnt_q};
          if (mem_accept) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) state_d = S_FILL;
          end
        end
        S_FILL: begin
          bus.memRead = 1'b1;
          if (mem_accept) begin
            bus.cacheWriteData = 1'b1;
            bus.cacheDataIn    = bus.memDataIn;
            cnt_d              = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) state_d = S_UPDATE;
          end
        end
        default: begin
          bus.cacheWriteTag   = 1'b1;
          bus.cacheWriteState = 1'b1;
          bus.cacheTagIn      = req_tag_q;
          bus.cacheStateIn    = ST_CLEAN;
          state_d             = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      victim_tag_q <= '0;
      req_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_tag_q <= victim_tag_d;
      req_tag_q    <= req_tag_d;
    end
  end
endmodule

// File: tb/tb_cpu_cache_controller.sv
// Directed bench for cpu_cache_controller: hits, clean/dirty misses, memory stalls,
// dropped requests and asynchronous reset during a write-back.
module tb_cpu_cache_controller;
  localparam int TW = 8, IW = 6, OW = 4, DW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cpu_cache_controller_if #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) bus ();

  cpu_cache_controller #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Cache data array: hit word, or victim line words D000+offset on a miss.
  logic        hit_mode;
  logic [15:0] hit_data;
  logic [15:0] line_base;
  int          n_checks = 0;
  int          n_pass   = 0;

  always_comb begin
    bus.cacheDataOut = hit_mode ? hit_data : (line_base + 16'(bus.cacheOffset));
    bus.memDataIn    = bus.memAddress[15:0] ^ 16'h5A5A;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.cpuRead = 1'b0; bus.cpuWrite = 1'b0; bus.cpuAddress = '0; bus.cpuWriteData = '0;
    bus.cacheHit = 1'b0; bus.cacheTagOut = '0; bus.cacheStateOut = 2'b01;
    bus.memWaitRequest = 1'b0;
    hit_mode = 1'b1; hit_data = '0; line_base = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.cpuRead = 1'b1; bus.cacheHit = 1'b1; hit_data = 16'hBEEF;
    repeat (2) @(posedge clock);
    #3;
    n_checks++;
    if ({bus.memRead, bus.memWrite, bus.cacheWriteData, bus.cacheWriteTag, bus.cacheWriteState, bus.accessEnable} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000", {bus.memRead, bus.memWrite, bus.cacheWriteData,
               bus.cacheWriteTag, bus.cacheWriteState, bus.accessEnable});
    else n_pass++;
    n_checks++;
    if (bus.cpuReadData !== 16'h0000) $display("FAIL reset_readdata: got %h want 0000", bus.cpuReadData);
    else n_pass++;
    reset = 1'b1;
    bus.cpuRead = 1'b0;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_read_hit();
    tick();
    bus.cpuAddress = {8'h12, 6'h05, 4'h9}; bus.cpuRead = 1'b1; bus.cacheHit = 1'b1; hit_data = 16'hBEEF;
    #1;
    n_checks++;
    if ({bus.cpuWaitRequest, bus.accessEnable} !== 2'b01) $display("FAIL rhit_wait_ae: got %b want 01", {bus.cpuWaitRequest, bus.accessEnable});
    else n_pass++;
    n_checks++;
    if (bus.cpuReadData !== 16'hBEEF) $display("FAIL rhit_data: got %h want beef", bus.cpuReadData);
    else n_pass++;
    n_checks++;
    if ({bus.cacheIndex, bus.cacheOffset, bus.memRead, bus.memWrite} !== {6'h05, 4'h9, 2'b00})
      $display("FAIL rhit_lookup: got %h/%h mem %b want 05/9 mem 00", bus.cacheIndex, bus.cacheOffset, {bus.memRead, bus.memWrite});
    else n_pass++;
    tick();
    bus.cpuRead = 1'b0;
    #1;
    n_checks++;
    if ({bus.accessEnable, bus.cpuWaitRequest, bus.memRead} !== 3'b000) $display("FAIL rhit_after: got %b want 000", {bus.accessEnable, bus.cpuWaitRequest, bus.memRead});
    else n_pass++;
    $display("test_read_hit done");
  endtask

  task automatic test_write_hit(input logic also_read, input logic [15:0] wdata);
    tick();
    bus.cpuAddress = {8'h34, 6'h2A, 4'h1}; bus.cpuWrite = 1'b1; bus.cpuRead = also_read;
    bus.cpuWriteData = wdata; bus.cacheHit = 1'b1; hit_data = 16'h0F0F;
    #1;
    n_checks++;
    if ({bus.cacheWriteData, bus.cacheWriteState, bus.cacheStateIn, bus.cacheWriteTag} !== 5'b11100)
      $display("FAIL whit_strobes rd=%b: got %b want 11100", also_read, {bus.cacheWriteData, bus.cacheWriteState, bus.cacheStateIn, bus.cacheWriteTag});
    else n_pass++;
    n_checks++;
    if (bus.cacheDataIn !== wdata) $display("FAIL whit_datain: got %h want %h", bus.cacheDataIn, wdata);
    else n_pass++;
    n_checks++;
    if ({bus.cpuWaitRequest, bus.accessEnable, bus.memRead, bus.memWrite, bus.cpuReadData} !== {4'b0100, 16'h0})
      $display("FAIL whit_misc: got %b %h want 0100 0000", {bus.cpuWaitRequest, bus.accessEnable, bus.memRead, bus.memWrite}, bus.cpuReadData);
    else n_pass++;
    tick();
    bus.cpuWrite = 1'b0; bus.cpuRead = 1'b0;
    #1;
    n_checks++;
    if ({bus.cacheWriteData, bus.memRead, bus.memWrite} !== 3'b000) $display("FAIL whit_after: got %b want 000", {bus.cacheWriteData, bus.memRead, bus.memWrite});
    else n_pass++;
    $display("test_write_hit rd=%b data=%h done", also_read, wdata);
  endtask

  task automatic test_miss(input logic wb, input logic [7:0] vtag, input logic [7:0] rtag, input logic [5:0] idx,
                           input logic wr, input int stall_word, input int exp_cycles);
    int cycles = 0;
    logic [17:0] a;
    tick();
    bus.cpuAddress = {rtag, idx, 4'h6}; bus.cpuRead = ~wr; bus.cpuWrite = wr; bus.cpuWriteData = 16'h7777;
    bus.cacheHit = 1'b0; hit_mode = 1'b0; line_base = 16'hD000; bus.cacheTagOut = vtag;
    bus.cacheStateOut = wb ? 2'b10 : 2'b01;
    #1;
    n_checks++;
    if ({bus.cpuWaitRequest, bus.accessEnable, bus.memRead, bus.memWrite} !== 4'b1000)
      $display("FAIL miss_idle: got %b want 1000", {bus.cpuWaitRequest, bus.accessEnable, bus.memRead, bus.memWrite});
    else n_pass++;
    if (wb) begin
      for (int w = 0; w < 16; w++) begin
        tick(); cycles++;
        bus.cacheTagOut = 8'hFF;
        #1;
        n_checks++;
        if (bus.memAddress !== {vtag, idx, 4'(w)}) $display("FAIL wb_addr w%0d: got %h want %h", w, bus.memAddress, {vtag, idx, 4'(w)});
        else n_pass++;
        n_checks++;
        if ({bus.memWrite, bus.memRead, bus.cpuWaitRequest, bus.memDataOut} !== {3'b101, 16'hD000 + 16'(w)})
          $display("FAIL wb_data w%0d: got %b %h want 101 %h", w, {bus.memWrite, bus.memRead, bus.cpuWaitRequest}, bus.memDataOut, 16'hD000 + 16'(w));
        else n_pass++;
      end
    end
    for (int w = 0; w < 16; w++) begin
      tick(); cycles++;
      a = {rtag, idx, 4'(w)};
      if (w == stall_word) begin
        bus.memWaitRequest = 1'b1;
        for (int s = 0; s < 5; s++) begin
          #1;
          n_checks++;
          if ({bus.memRead, bus.cacheWriteData, bus.memAddress} !== {2'b10, a})
            $display("FAIL stall s%0d: got %b %h want 10 %h", s, {bus.memRead, bus.cacheWriteData}, bus.memAddress, a);
          else n_pass++;
          tick(); cycles++;
        end
        bus.memWaitRequest = 1'b0;
      end
      #1;
      n_checks++;
      if ({bus.memRead, bus.memWrite, bus.cacheWriteData, bus.cpuWaitRequest, bus.memAddress} !== {4'b1011, a})
        $display("FAIL fill w%0d: got %b %h want 1011 %h", w, {bus.memRead, bus.memWrite, bus.cacheWriteData, bus.cpuWaitRequest}, bus.memAddress, a);
      else n_pass++;
      n_checks++;
      if ({bus.cacheDataIn, bus.cacheOffset} !== {a[15:0] ^ 16'h5A5A, 4'(w)})
        $display("FAIL fill_data w%0d: got %h/%h want %h/%h", w, bus.cacheDataIn, bus.cacheOffset, a[15:0] ^ 16'h5A5A, 4'(w));
      else n_pass++;
    end
    tick(); cycles++;
    #1;
    n_checks++;
    if ({bus.cacheWriteTag, bus.cacheWriteState, bus.cacheWriteData, bus.cacheStateIn, bus.cacheTagIn, bus.cpuWaitRequest, bus.memRead}
        !== {3'b110, 2'b01, rtag, 2'b10})
      $display("FAIL update: got %b %b %h %b want 110 01 %h 10", {bus.cacheWriteTag, bus.cacheWriteState, bus.cacheWriteData},
               bus.cacheStateIn, bus.cacheTagIn, {bus.cpuWaitRequest, bus.memRead}, rtag);
    else n_pass++;
    tick(); cycles++;
    bus.cacheHit = 1'b1; hit_mode = 1'b1; hit_data = 16'hC0DE; bus.cacheStateOut = 2'b01;
    #1;
    n_checks++;
    if ({bus.cpuWaitRequest, bus.accessEnable} !== 2'b01) $display("FAIL miss_done: got %b want 01", {bus.cpuWaitRequest, bus.accessEnable});
    else n_pass++;
    n_checks++;
    if (wr && {bus.cacheWriteData, bus.cacheStateIn, bus.cacheDataIn} !== {3'b110, 16'h7777})
      $display("FAIL miss_wr_done: got %b %b %h want 1 10 7777", bus.cacheWriteData, bus.cacheStateIn, bus.cacheDataIn);
    else if (!wr && bus.cpuReadData !== 16'hC0DE) $display("FAIL miss_rd_done: got %h want c0de", bus.cpuReadData);
    else n_pass++;
    n_checks++;
    if (cycles !== exp_cycles) $display("FAIL miss_latency: got %0d want %0d", cycles, exp_cycles);
    else n_pass++;
    tick();
    bus.cpuRead = 1'b0; bus.cpuWrite = 1'b0; bus.cacheHit = 1'b0;
    $display("test_miss wb=%b wr=%b stall=%0d cycles=%0d done", wb, wr, stall_word, cycles);
  endtask

  task automatic test_drop();
    tick();
    bus.cpuAddress = {8'h55, 6'h11, 4'h0}; bus.cpuRead = 1'b1;
    bus.cacheHit = 1'b0; hit_mode = 1'b0; bus.cacheStateOut = 2'b01;
    for (int w = 0; w < 16; w++) begin
      tick();
      if (w == 3) bus.cpuRead = 1'b0;
      #1;
      n_checks++;
      if ({bus.memRead, bus.memAddress} !== {1'b1, 8'h55, 6'h11, 4'(w)})
        $display("FAIL drop_fill w%0d: got %b %h want 1 %h", w, bus.memRead, bus.memAddress, {8'h55, 6'h11, 4'(w)});
      else n_pass++;
    end
    n_checks++;
    if (bus.cpuWaitRequest !== 1'b0) $display("FAIL drop_wait: got %b want 0", bus.cpuWaitRequest);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({bus.cacheWriteTag, bus.cacheWriteState} !== 2'b11) $display("FAIL drop_update: got %b want 11", {bus.cacheWriteTag, bus.cacheWriteState});
    else n_pass++;
    tick();
    bus.cacheHit = 1'b1; hit_mode = 1'b1;
    #1;
    n_checks++;
    if ({bus.accessEnable, bus.cpuWaitRequest, bus.memRead, bus.cacheWriteTag} !== 4'b0000)
      $display("FAIL drop_idle: got %b want 0000", {bus.accessEnable, bus.cpuWaitRequest, bus.memRead, bus.cacheWriteTag});
    else n_pass++;
    bus.cacheHit = 1'b0;
    $display("test_drop done");
  endtask

  task automatic test_reset_midwb();
    tick();
    bus.cpuAddress = {8'h21, 6'h33, 4'h2}; bus.cpuWrite = 1'b1; bus.cpuWriteData = 16'h4444;
    bus.cacheHit = 1'b0; hit_mode = 1'b0; line_base = 16'hD000; bus.cacheTagOut = 8'h3C; bus.cacheStateOut = 2'b10;
    for (int w = 0; w < 10; w++) tick();
    #1;
    n_checks++;
    if ({bus.memWrite, bus.memAddress} !== {1'b1, 8'h3C, 6'h33, 4'h9})
      $display("FAIL rst_pre: got %b %h want 1 %h", bus.memWrite, bus.memAddress, {8'h3C, 6'h33, 4'h9});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.memWrite, bus.memRead, bus.cacheWriteData, bus.cacheWriteTag, bus.cacheWriteState, bus.accessEnable} !== 6'b0)
      $display("FAIL rst_async: got %b want 000000", {bus.memWrite, bus.memRead, bus.cacheWriteData,
               bus.cacheWriteTag, bus.cacheWriteState, bus.accessEnable});
    else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.memWrite, bus.cpuWaitRequest, bus.cacheOffset} !== {2'b01, 4'h2})
      $display("FAIL rst_idle: got %b %h want 01 2", {bus.memWrite, bus.cpuWaitRequest}, bus.cacheOffset);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({bus.memWrite, bus.memAddress} !== {1'b1, 8'h3C, 6'h33, 4'h0})
      $display("FAIL rst_restart: got %b %h want 1 %h", bus.memWrite, bus.memAddress, {8'h3C, 6'h33, 4'h0});
    else n_pass++;
    reset = 1'b0;
    bus.cpuWrite = 1'b0;
    #1;
    reset = 1'b1;
    $display("test_reset_midwb done");
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit(1'b0, 16'h1234);
    test_write_hit(1'b1, 16'hABCD);
    test_miss(1'b0, 8'h11, 8'hA7, 6'h15, 1'b0, -1, 18);
    test_miss(1'b1, 8'h3C, 8'h42, 6'h0B, 1'b1, -1, 34);
    test_miss(1'b0, 8'h22, 8'h9E, 6'h3F, 1'b0, 7, 23);
    test_drop();
    test_reset_midwb();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_cache_controller.md
CPU_CACHE_CONTROLLER -- requirements
Module: cpu_cache_controller

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 8, meaning tag bits of cpuAddress.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, meaning set-index bits of cpuAddress.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 4, meaning word-offset bits; line = 2^OFFSET_WIDTH words.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, meaning word width.
REQ-005 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cpuRead and cpuWrite, input, 1 each, CPU read/write request, held until cpuWaitRequest=0.
REQ-008 SHALL have port cpuAddress, input, TAG+INDEX+OFFSET, {tag,index,offset}, stable while request pending.
REQ-009 SHALL have port cpuWriteData, input, DATA_WIDTH, write word.
REQ-010 SHALL have port cpuReadData, output, DATA_WIDTH, read word, valid in completion cycle.
REQ-011 SHALL have port cpuWaitRequest, output, 1, high while a pending request is not completing.
REQ-012 SHALL have ports cacheIndex and cacheOffset, outputs, INDEX_WIDTH and OFFSET_WIDTH, cache lookup address.
REQ-013 SHALL have ports cacheTagIn, cacheDataIn, cacheStateIn, outputs, TAG_WIDTH, DATA_WIDTH, 2, write values.
REQ-014 SHALL have ports cacheWriteTag, cacheWriteData, cacheWriteState, outputs, 1 each, cache write strobes.
REQ-015 SHALL have port cacheHit, input, 1, combinational hit for current index/tag.
REQ-016 SHALL have ports cacheTagOut, cacheDataOut, cacheStateOut, inputs, TAG_WIDTH, DATA_WIDTH, 2; hit line on hit, LRU victim line on miss.
REQ-017 SHALL have port accessEnable, output, 1, replacement-algorithm access update strobe.
REQ-018 SHALL have ports memRead and memWrite, outputs, 1 each, memory word transfer request.
REQ-019 SHALL have port memAddress, output, TAG+INDEX+OFFSET, memory word address.
REQ-020 SHALL have ports memDataOut output and memDataIn input, DATA_WIDTH, write/read data.
REQ-021 SHALL have port memWaitRequest, input, 1; a transfer is accepted in a cycle where request=1 and memWaitRequest=0.

Function
REQ-022 SHALL use state encoding INVALID=2'b00, CLEAN=2'b01, DIRTY=2'b10; FSM states IDLE, WRITEBACK, FILL, UPDATE.
REQ-023 SHALL drive cacheIndex from cpuAddress index in all states; cacheOffset = cpuAddress offset in IDLE, word counter otherwise.
REQ-024 IDLE with request and cacheHit=1: cpuWaitRequest=0 and accessEnable=1 same cycle (zero-wait hit); read returns cpuReadData=cacheDataOut; write asserts cacheWriteData, cacheWriteState with cacheDataIn=cpuWriteData, cacheStateIn=DIRTY.
REQ-025 cpuRead and cpuWrite both high SHALL be treated as a write.
REQ-026 IDLE with request and cacheHit=0: cpuWaitRequest=1, latch victim tag, clear counter; go WRITEBACK if cacheStateOut=DIRTY, else FILL.
REQ-027 WRITEBACK: memWrite=1, memAddress={victimTag,index,counter}, memDataOut=cacheDataOut; counter increments on acceptance; acceptance at counter=max SHALL wrap counter to 0 and go FILL.
REQ-028 FILL: memRead=1, memAddress={reqTag,index,counter}; on acceptance cacheWriteData=1, cacheDataIn=memDataIn, counter++; acceptance at max wraps to 0 and goes UPDATE.
REQ-029 UPDATE: one cycle, cacheWriteTag=1, cacheWriteState=1, cacheTagIn=reqTag, cacheStateIn=CLEAN; then IDLE, where the request completes as a hit.
REQ-030 memWaitRequest held high SHALL hold state, counter, and address unchanged indefinitely.
REQ-031 Request dropped mid-miss SHALL not abort the line transfer; no completion issued.
REQ-032 cpuWaitRequest SHALL be 1 in WRITEBACK, FILL, UPDATE whenever a request is present; accessEnable SHALL be 0 outside completing hit cycles.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, counter=0, and all strobes (mem*, cacheWrite*, accessEnable) to 0, including mid-WRITEBACK/FILL; cpuReadData=0.

Verification
REQ-034 Read hit, cacheHit=1, cacheDataOut=16'hBEEF -> same cycle cpuWaitRequest=0, cpuReadData=16'hBEEF, accessEnable=1.
REQ-035 Write hit, data 16'h1234 -> one cycle cacheWriteData=1, cacheWriteState=1, cacheStateIn=2'b10, no mem activity.
REQ-036 Read miss, victim CLEAN, memWaitRequest=0 -> 16 memRead cycles, addresses offset 0..15, UPDATE, completion 18 cycles after request.
REQ-037 Write miss, victim DIRTY tag 8'h3C -> 16 memWrite to {8'h3C,index,0..15}, then 16 fills, UPDATE, write completes with DIRTY.
REQ-038 memWaitRequest high 5 cycles at FILL word 7 -> memAddress held at word 7, no cacheWriteData until release.
REQ-039 reset=0 during WRITEBACK word 9 -> memWrite drops asynchronously, FSM IDLE, counter 0; next miss restarts at word 0.
